// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// conv_result_writer : ReLU + row/col tagging + FWFT FIFO at the adder-tree sink
// Rev 1.0
// ============================================================================
module conv_result_writer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MAP_COLS   = 26,
  parameter int MAP_ROWS   = 26
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last_col,
  output logic                          out_last_frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
  localparam int ENT_W = DATA_W + 2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Entry layout: {last_frame, last_col, pixel}
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] pixel;
  logic              tag_last_col;
  logic              tag_last_frame;
  logic [ENT_W-1:0]  head;

  assign full      = (fifo_count == CNT_FULL);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push      = in_valid && (!full || pop);

  assign pixel          = in_data[DATA_W-1] ? '0 : in_data;
  assign tag_last_col   = (col == COL_LAST);
  assign tag_last_frame = tag_last_col && (row == ROW_LAST);

  assign head           = out_valid ? mem[rd_ptr] : '0;
  assign out_data       = head[DATA_W-1:0];
  assign out_last_col   = head[DATA_W];
  assign out_last_frame = head[DATA_W+1];

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= {tag_last_frame, tag_last_col, pixel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      col        <= '0;
      row        <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      col        <= '0;
      row        <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Geometry follows every upstream sample, dropped or not.
      if (in_valid) begin
        if (tag_last_col) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (in_valid && full && !pop) overflow <= 1'b1;

      frame_done <= pop && head[DATA_W+1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// Randomized bench for conv_result_writer against a queue-based reference model.
module tb_conv_result_writer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int COLS   = 4;
  localparam int ROWS   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last_col;
  logic       out_last_frame;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_done;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of {last_frame, last_col, pixel}
  logic [9:0] q[$];
  int pos;
  bit ovf;
  bit fd;

  conv_result_writer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MAP_COLS(COLS), .MAP_ROWS(ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last_col(out_last_col), .out_last_frame(out_last_frame),
    .fifo_count(fifo_count), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, out_data, out_last_col, out_last_frame, fifo_count, overflow, frame_done};

  function automatic void model_reset();
    q.delete();
    pos = 0;
    ovf = 1'b0;
    fd  = 1'b0;
  endfunction

  function automatic void model_advance(bit v, logic [7:0] d, bit r, bit c);
    logic [9:0] h;
    logic [9:0] e;
    int cc;
    int rr;
    if (c) begin
      model_reset();
      return;
    end
    fd = 1'b0;
    if (q.size() != 0 && r) begin
      h  = q.pop_front();
      fd = h[9];
    end
    if (v) begin
      cc = pos % COLS;
      rr = (pos / COLS) % ROWS;
      e  = {(cc == COLS-1) && (rr == ROWS-1), cc == COLS-1, d[7] ? 8'd0 : d};
      if (q.size() < DEPTH) q.push_back(e);
      else ovf = 1'b1;
      pos++;
    end
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [9:0] h;
    h = (q.size() != 0) ? q[0] : 10'd0;
    return {q.size() != 0, h[7:0], h[8], h[9], 4'(q.size()), ovf, fd};
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    model_advance(v, d, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", obs, 17'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [7:0] s [8];
    logic [7:0] r [8];
    int pulses;
    s = '{8'd5, 8'hFD, 8'd127, 8'h80, 8'd0, 8'd1, 8'hFF, 8'd64};
    r = '{8'd5, 8'd0, 8'd127, 8'd0, 8'd0, 8'd1, 8'd0, 8'd64};
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s[i], 1'b1, 1'b0);
      if (frame_done) pulses++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL stream_model cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      checks++;
      if ({out_valid, out_data, out_last_col, out_last_frame} !== {1'b1, r[i], i == 3 || i == 7, i == 7}) begin
        errors++;
        $display("FAIL stream_pixel %0d got %b_%h_%b%b exp %h lc %0d lf %0d",
                 i, out_valid, out_data, out_last_col, out_last_frame, r[i], i == 3 || i == 7, i == 7);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      if (frame_done) pulses++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL stream_tail cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL frame_done_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_fill cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state got count %0d ovf %b exp count 8 ovf 1", fifo_count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_drain cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    // 11th sample lands at col 2, the 12th at col 3 (last column)
    drive(1'b1, 8'd17, 1'b0, 1'b0);
    drive(1'b1, 8'd18, 1'b0, 1'b0);
    checks++;
    if ({out_data, out_last_col} !== {8'd17, 1'b0} || obs !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_col2 got %h exp %h", obs, exp_vec());
    end
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if ({out_data, out_last_col} !== {8'd18, 1'b1} || obs !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_col3 got %h exp %h", obs, exp_vec());
    end
    drive(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_full_simul();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_simul cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_simul_state got count %0d ovf %b exp count 8 ovf 0", fifo_count, overflow);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    bit rdy [4];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 24; i++) begin
      drive(i < 16 ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom), rdy[i % 4], 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 9; i++) drive(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (fifo_count !== 4'd3 || overflow !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL clear_pre got %h exp %h", obs, exp_vec());
    end
    drive(1'b1, 8'd9, 1'b1, 1'b1);
    checks++;
    if ({fifo_count, out_valid, overflow, frame_done} !== 7'd0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL clear_post got %h exp %h", obs, exp_vec());
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL clear_tags cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      drive(1'b0, 8'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom_range(1, 127)), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs, 17'd0);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset cyc %0d got %h exp %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (out_last_frame !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lf got %b exp 1", out_last_frame);
    end
    drive(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_simul();
    test_stall();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
